// File: rtl/partial_sum_folder_pkg.sv
// Shared defaults and FSM encoding for the sequential partial-sum folder.
package partial_sum_fold_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = IN_W + $clog2(LANES);
  localparam int unsigned IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/partial_sum_folder_lane_select.sv
// LANES:1 mux picking one IN_W-bit lane out of the packed lane register.
module lane_select #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [LANES*IN_W-1:0] lanes,
  input  logic [IDX_W-1:0]      idx,
  output logic [IN_W-1:0]       lane
);

  always_comb begin
    lane = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (idx == IDX_W'(k)) lane = lanes[k*IN_W +: IN_W];
    end
  end

endmodule

// File: rtl/partial_sum_folder.sv
// Folds LANES partial sums into one total with a single shared adder,
// one lane per cycle, behind valid/ready handshakes on both sides.
module partial_sum_folder
  import partial_sum_fold_pkg::*;
#(
  parameter int unsigned LANES = partial_sum_fold_pkg::LANES,
  parameter int unsigned IN_W  = partial_sum_fold_pkg::IN_W,
  parameter int unsigned OUT_W = partial_sum_fold_pkg::OUT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_sums,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_sum
);

  localparam int unsigned IDX_W_L = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                  state_q, state_d;
  logic [LANES*IN_W-1:0]   lanes_q;
  logic [OUT_W-1:0]        acc_q;
  logic [IDX_W_L-1:0]      idx_q;
  logic [IN_W-1:0]         lane_val;
  logic                    accept;
  logic                    last;

  lane_select #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .IDX_W (IDX_W_L)
  ) u_lane_select (
    .lanes (lanes_q),
    .idx   (idx_q),
    .lane  (lane_val)
  );

  assign last   = (idx_q == IDX_W_L'(LANES - 1));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DONE with out_ready doubles as an accept slot, so streaming needs no IDLE bubble.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      lanes_q <= in_sums;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == ACCUM) begin
      acc_q <= acc_q + {{(OUT_W-IN_W){1'b0}}, lane_val};
      idx_q <= last ? '0 : idx_q + IDX_W_L'(1);
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;

endmodule

// File: tb/tb_partial_sum_folder.sv
// Self-checking bench for partial_sum_folder: vector table, corner sequences,
// and randomized streaming against a plain-arithmetic lane-sum reference.
module tb_partial_sum_folder;

  localparam int unsigned LANES = 8;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 11;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_sums;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string                 name;
    logic [LANES*IN_W-1:0] sums;
    int                    exp;
  } vec_t;

  vec_t tbl[6];

  partial_sum_folder #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sums   (in_sums),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  function automatic int ref_sum(input logic [LANES*IN_W-1:0] v);
    int s = 0;
    for (int k = 0; k < LANES; k++) s += int'(v[k*IN_W +: IN_W]);
    return s;
  endfunction

  function automatic logic [LANES*IN_W-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE just after an edge; out_ready held high throughout.
  task automatic do_txn(input logic [LANES*IN_W-1:0] v, input int exp, input string name);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sums   = v;
    tick();
    in_valid = 1'b0;
    in_sums  = rand_vec();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, " latency"}, n, LANES);
    chk({name, " sum"}, int'(out_sum), exp);
    tick();
    chk({name, " in_ready after"}, int'(in_ready), 1);
    chk({name, " out_valid after"}, int'(out_valid), 0);
  endtask

  initial begin
    int n, exp_hold, received, sent, since, rst_exp;
    int exp_q[$];
    logic [LANES*IN_W-1:0] v;

    tbl[0] = '{"zeros",    64'h0000000000000000, 0};
    tbl[1] = '{"ramp1to8", 64'h0807060504030201, 36};
    tbl[2] = '{"all_ff",   64'hFFFFFFFFFFFFFFFF, 2040};
    tbl[3] = '{"all_01",   64'h0101010101010101, 8};
    tbl[4] = '{"alt_ff",   64'h00FF00FF00FF00FF, 1020};
    tbl[5] = '{"ends_80",  64'h8000000000000080, 256};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_sums   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_sum", int'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_txn(tbl[i].sums, tbl[i].exp, tbl[i].name);

    // Stall in DONE with noisy inputs, then back-to-back accept on release.
    v = rand_vec();
    exp_hold = ref_sum(v);
    in_valid = 1'b1;
    in_sums  = v;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall latency", n, LANES);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom);
      in_sums  = rand_vec();
      #1;
      chk("stall out_valid", int'(out_valid), 1);
      chk("stall out_sum", int'(out_sum), exp_hold);
      chk("stall in_ready", int'(in_ready), 0);
      tick();
    end
    chk("stall final out_sum", int'(out_sum), exp_hold);
    in_valid  = 1'b1;
    in_sums   = {LANES{8'd10}};
    out_ready = 1'b1;
    #1;
    chk("release in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_sums  = rand_vec();
    chk("b2b accepted", int'(out_valid), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("b2b latency", n, LANES);
    chk("b2b sum", int'(out_sum), 80);
    tick();

    // Asynchronous reset during the fourth accumulate cycle.
    in_valid = 1'b1;
    in_sums  = 64'h2222222222222222;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst out_sum", int'(out_sum), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_txn(64'h0101010101010101, 8, "post_reset");

    // Streaming: 20 random vectors, out_ready held high.
    out_ready = 1'b1;
    received = 0;
    sent = 0;
    since = 0;
    for (int cyc = 0; cyc < 20 * (LANES + 1) + 40 && received < 20; cyc++) begin
      if (out_valid) begin
        rst_exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("stream sum", int'(out_sum), rst_exp);
        if (received > 0) chk("stream interval", since, LANES + 1);
        received++;
        since = 0;
      end
      if (in_ready && sent < 20) begin
        v = rand_vec();
        in_valid = 1'b1;
        in_sums  = v;
        exp_q.push_back(ref_sum(v));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      since++;
    end
    in_valid = 1'b0;
    chk("stream received", received, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
